// File: rtl/mask_write_arbiter_if.sv
// Bundle between NUM_REQ mask producers, the arbiter and the mask register write port.
// Signal suffixes are from the arbiter's point of view.
interface mask_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int MVL     = 16,
  parameter int VLW     = $clog2(MVL) + 1
);
  logic [NUM_REQ-1:0]     req_i;
  logic [NUM_REQ*VLW-1:0] req_vlr_i;
  logic [NUM_REQ-1:0]     bit_i;
  logic [NUM_REQ-1:0]     bit_valid_i;
  logic [NUM_REQ-1:0]     gnt_o;
  logic [NUM_REQ-1:0]     bit_ready_o;
  logic [NUM_REQ-1:0]     done_o;
  logic                   mv_w_o;
  logic [VLW-1:0]         mv_vlr_o;
  logic [1:0]             mv_wd_o;
  logic                   mv_busy_i;
  logic                   mv_ready_i;

  modport slave (
    input  req_i, req_vlr_i, bit_i, bit_valid_i, mv_busy_i, mv_ready_i,
    output gnt_o, bit_ready_o, done_o, mv_w_o, mv_vlr_o, mv_wd_o
  );

  modport master (
    output req_i, req_vlr_i, bit_i, bit_valid_i, mv_busy_i, mv_ready_i,
    input  gnt_o, bit_ready_o, done_o, mv_w_o, mv_vlr_o, mv_wd_o
  );
endinterface

// File: rtl/mask_write_arbiter.sv
// Arbitrates the mask-register write port among NUM_REQ producers and streams the winner's bits.
// Define MASK_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mwa_lane (
  input  logic gnt_i,
  input  logic can_acc_i,
  input  logic done_ev_i,
  output logic bit_ready_o,
  output logic done_o
);
  assign bit_ready_o = gnt_i & can_acc_i;
  assign done_o      = gnt_i & done_ev_i;
endmodule

module mask_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MVL     = 16,
  parameter int VLW     = $clog2(MVL) + 1
) (
  input logic                  clk,
  input logic                  rst_n,
  mask_write_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [VLW-1:0] MVL_V = VLW'(MVL);

  typedef enum logic [1:0] {IDLE, START, XFER, WAIT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [VLW-1:0]     vlr_q, vlr_d;
  logic [VLW-1:0]     cnt_q, cnt_d;
  logic               zdone_q, zdone_d;

  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [VLW-1:0]     win_vlr;
  logic               g_bit, g_vld;
  logic               can_acc, done_ev, mv_w, acc;
  logic [1:0]         wd;
  logic [NUM_REQ-1:0] rdy_w, done_w;

`ifdef MASK_ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`else
  // ptr_q holds where the next search starts (last winner + 1)
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_vld && bus.req_i[j]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && !zdone_q && win_vld && !bus.mv_busy_i)
      ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    logic [VLW-1:0] raw;
    raw     = bus.req_vlr_i[win_idx*VLW +: VLW];
    win_vlr = (raw > MVL_V) ? MVL_V : raw;
  end

  assign g_bit = |(bus.bit_i & gnt_q);
  assign g_vld = |(bus.bit_valid_i & gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vlr_d   = vlr_q;
    cnt_d   = cnt_q;
    zdone_d = 1'b0;
    mv_w    = 1'b0;
    wd      = 2'b00;
    can_acc = 1'b0;
    acc     = 1'b0;
    done_ev = 1'b0;
    case (state_q)
      IDLE: begin
        // A zero-length grant completes here; hold off arbitration so the requester can drop req
        if (zdone_q) begin
          done_ev = 1'b1;
          gnt_d   = '0;
        end else if (win_vld && !bus.mv_busy_i) begin
          gnt_d = NUM_REQ'(1) << win_idx;
          vlr_d = win_vlr;
          if (win_vlr == '0) zdone_d = 1'b1;
          else               state_d = START;
        end
      end
      START: begin
        mv_w    = 1'b1;
        cnt_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        can_acc = (cnt_q < vlr_q);
        acc     = can_acc & g_vld;
        wd      = {acc, g_bit};
        if (acc) begin
          cnt_d = cnt_q + VLW'(1);
          if (cnt_q + VLW'(1) == vlr_q) state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mv_ready_i && !bus.mv_busy_i) begin
          done_ev = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vlr_q   <= '0;
      cnt_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vlr_q   <= vlr_d;
      cnt_q   <= cnt_d;
      zdone_q <= zdone_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mwa_lane u_lane (
      .gnt_i       (gnt_q[i]),
      .can_acc_i   (can_acc),
      .done_ev_i   (done_ev),
      .bit_ready_o (rdy_w[i]),
      .done_o      (done_w[i])
    );
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.bit_ready_o = rdy_w;
  assign bus.done_o      = done_w;
  assign bus.mv_w_o      = mv_w;
  assign bus.mv_vlr_o    = vlr_q;
  assign bus.mv_wd_o     = wd;
endmodule

// File: tb/tb_mask_write_arbiter.sv
// Randomized bench for mask_write_arbiter with a transaction-level grant/latency model
// and a behavioural mask register on the write port.
module tb_mask_write_arbiter;
  localparam int N   = 4;
  localparam int MVL = 16;
  localparam int VLW = $clog2(MVL) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mask_write_arbiter_if #(.NUM_REQ(N), .MVL(MVL), .VLW(VLW)) bus ();
  mask_write_arbiter #(.NUM_REQ(N), .MVL(MVL), .VLW(VLW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Mask register: busy the cycle after the write pulse, ready once vlr bits are stored
  logic           mbusy, mready, force_busy;
  logic [MVL-1:0] mmask;
  int             mcnt, mvlr;
  assign bus.mv_busy_i  = mbusy | force_busy;
  assign bus.mv_ready_i = mready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy <= 1'b0; mready <= 1'b0; mmask <= '0; mcnt <= 0; mvlr <= 0;
    end else if (bus.mv_w_o) begin
      mbusy <= 1'b1; mready <= 1'b0; mmask <= '0; mcnt <= 0; mvlr <= int'(bus.mv_vlr_o);
    end else if (mbusy && bus.mv_wd_o[1]) begin
      if (mcnt < MVL) mmask[mcnt] <= bus.mv_wd_o[0];
      mcnt <= mcnt + 1;
      if (mcnt + 1 == mvlr) begin
        mbusy <= 1'b0; mready <= 1'b1;
      end
    end
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          ptr = 0;
  int          vlr_r  [N];
  logic [31:0] bits_r [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  function automatic int clampv(input int v);
    return (v > MVL) ? MVL : v;
  endfunction

  function automatic int pick();
`ifdef MASK_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (bus.req_i[i]) return i;
`else
    for (int k = 0; k < N; k++) if (bus.req_i[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input int v, input logic [31:0] b);
    vlr_r[i]  = v;
    bits_r[i] = b;
    bus.req_vlr_i[i*VLW +: VLW] = VLW'(v);
    bus.req_i[i] = 1'b1;
  endtask

  // One whole grant, called at a negedge while the DUT is idle with requests visible.
  // pct<0 takes the granted lane's valid from vpat; abort_at>=0 pulses reset in that XFER cycle.
  task automatic do_grant(input int pct, input logic [31:0] vpat, input int abort_at, output int gobs);
    int w, cv, acc, cyc;
    logic v;
    logic [N-1:0] vv, bb, oh;
    gobs = -1;
    w = pick();
    if (w < 0) return;
    ptr = (w + 1) % N;
    cv  = clampv(vlr_r[w]);
    oh  = N'(1) << w;
    tick();
    bus.bit_valid_i = N'($urandom);
    bus.bit_i       = N'($urandom);
    smp();
    for (int i = 0; i < N; i++) if (bus.gnt_o[i]) gobs = i;
    chk("gnt", bus.gnt_o, oh);
    chk("mv_w", bus.mv_w_o, cv != 0);
    if (cv == 0) begin
      chk("zero_done", bus.done_o, oh);
      chk("zero_wd", bus.mv_wd_o, 0);
      tick(); bus.req_i[w] = 1'b0; smp();
      chk("zero_gnt_clr", bus.gnt_o, 0);
      chk("zero_done_clr", bus.done_o, 0);
      return;
    end
    chk("start_vlr", bus.mv_vlr_o, cv);
    chk("start_wd", bus.mv_wd_o, 0);
    chk("start_rdy", bus.bit_ready_o, 0);
    acc = 0; cyc = 0;
    while (acc < cv && cyc < 400) begin
      tick();
      v  = (pct < 0) ? vpat[cyc % 32] : ($urandom_range(99) < pct);
      vv = N'($urandom); bb = N'($urandom);
      vv[w] = v; bb[w] = bits_r[w][acc];
      bus.bit_valid_i = vv; bus.bit_i = bb;
      if (cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", bus.gnt_o, 0);
        chk("rst_rdy", bus.bit_ready_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_mvw", bus.mv_w_o, 0);
        chk("rst_vlr", bus.mv_vlr_o, 0);
        chk("rst_wd", bus.mv_wd_o, 0);
        smp();
        rst_n = 1'b1; bus.req_i = '0; ptr = 0;
        return;
      end
      smp();
      chk("xfer_rdy", bus.bit_ready_o, oh);
      chk("xfer_wd", bus.mv_wd_o, {v, bb[w]});
      chk("xfer_done", bus.done_o, 0);
      if (v) acc++;
      cyc++;
    end
    chk("beats", acc, cv);
    tick(); bus.bit_valid_i = N'($urandom); smp();
    chk("done", bus.done_o, oh);
    chk("wait_rdy", bus.bit_ready_o, 0);
    chk("wait_wd_vld", bus.mv_wd_o[1], 0);
    chk("mask", mmask, bits_r[w] & ((32'h1 << cv) - 1));
    tick(); bus.req_i[w] = 1'b0; smp();
    chk("idle_gnt", bus.gnt_o, 0);
    chk("idle_done", bus.done_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g, expw;
    force_busy      = 1'b0;
    bus.req_i       = '0;
    bus.req_vlr_i   = '0;
    bus.bit_i       = '0;
    bus.bit_valid_i = '0;
    repeat (2) @(negedge clk);
    chk("rst0_gnt", bus.gnt_o, 0);
    chk("rst0_rdy", bus.bit_ready_o, 0);
    chk("rst0_done", bus.done_o, 0);
    chk("rst0_mvw", bus.mv_w_o, 0);
    chk("rst0_vlr", bus.mv_vlr_o, 0);
    chk("rst0_wd", bus.mv_wd_o, 0);
    rst_n = 1'b1;
    smp();

    // all four held, length 2 each
    for (int i = 0; i < N; i++) set_req(i, 2, $urandom);
    for (int k = 0; k < 5; k++) begin
`ifdef MASK_ARB_FIXED_PRIO_EN
      expw = 0;
`else
      expw = k % N;
`endif
      do_grant(100, 0, -1, g);
      chk("rr_order", g, expw);
      set_req(g, 2, $urandom);
    end
    bus.req_i = '0;
    smp();

    set_req(0, 5, 32'b01101);
    do_grant(100, 0, -1, g);
    chk("single_mask", mmask, 16'b01101);

    set_req(1, 0, 0);
    do_grant(100, 0, -1, g);
    chk("zero_who", g, 1);

    set_req(3, 20, $urandom);
    do_grant(100, 0, -1, g);

    set_req(2, 3, 32'b101);
    do_grant(-1, 32'b11001, -1, g);

    force_busy = 1'b1;
    set_req(1, 3, $urandom);
    repeat (3) begin
      tick(); smp();
      chk("busy_hold_gnt", bus.gnt_o, 0);
      chk("busy_hold_mvw", bus.mv_w_o, 0);
    end
    force_busy = 1'b0;
    do_grant(100, 0, -1, g);
    chk("busy_who", g, 1);

    set_req(0, 8, $urandom);
    do_grant(100, 0, 3, g);
    set_req(2, 4, $urandom);
    do_grant(100, 0, -1, g);
    chk("post_rst_who", g, 2);

    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_i[i] && $urandom_range(2) == 0)
          set_req(i, ($urandom_range(4) == 0) ? 0 : int'($urandom_range(20)), $urandom);
      end
      if (bus.req_i != '0) begin
        do_grant(int'($urandom_range(100, 30)), 0, -1, g);
      end else begin
        tick(); smp();
        chk("idle_nogrant", bus.gnt_o, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
